// File: rtl/block_completion_tracker.sv
// Tracks register writes, stores and the branch of every in-flight block frame,
// releasing completed frames oldest-first and discarding frames on a speculative flush.
module block_completion_tracker #(
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned FRAME_W    = $clog2(NUM_FRAMES),
  parameter int unsigned LSID_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  output logic [FRAME_W-1:0]    alloc_frame_o,
  input  logic [2**LSID_W-1:0]  alloc_store_mask_i,
  input  logic [4:0]            alloc_num_reg_writes_i,
  input  logic                  wr_valid_i,
  input  logic [FRAME_W-1:0]    wr_frame_i,
  input  logic                  st_valid_i,
  input  logic [FRAME_W-1:0]    st_frame_i,
  input  logic [LSID_W-1:0]     st_lsid_i,
  input  logic                  br_valid_i,
  input  logic [FRAME_W-1:0]    br_frame_i,
  input  logic [4:0]            br_exit_id_i,
  input  logic                  flush_valid_i,
  input  logic [FRAME_W-1:0]    flush_frame_i,
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output logic [FRAME_W-1:0]    commit_frame_o,
  output logic [4:0]            commit_exit_id_o,
  output logic                  protocol_error_o,
  output logic [NUM_FRAMES-1:0] frames_busy_o
);

  localparam int unsigned MaskW = 2 ** LSID_W;
  localparam int unsigned CntW  = FRAME_W + 1;

  logic [NUM_FRAMES-1:0] valid_q, valid_d;
  logic [NUM_FRAMES-1:0] br_seen_q, br_seen_d;
  logic [MaskW-1:0]      store_mask_q [NUM_FRAMES];
  logic [MaskW-1:0]      store_mask_d [NUM_FRAMES];
  logic [MaskW-1:0]      seen_mask_q  [NUM_FRAMES];
  logic [MaskW-1:0]      seen_mask_d  [NUM_FRAMES];
  logic [4:0]            need_wr_q    [NUM_FRAMES];
  logic [4:0]            need_wr_d    [NUM_FRAMES];
  logic [4:0]            wr_cnt_q     [NUM_FRAMES];
  logic [4:0]            wr_cnt_d     [NUM_FRAMES];
  logic [4:0]            exit_id_q    [NUM_FRAMES];
  logic [4:0]            exit_id_d    [NUM_FRAMES];

  logic [FRAME_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               error_q, error_d;

  logic [NUM_FRAMES-1:0] complete;
  logic [NUM_FRAMES-1:0] discard;
  logic [FRAME_W-1:0]    flush_dist;
  logic                  flush_hit;
  logic                  alloc_fire;
  logic                  commit_fire;

  always_comb begin
    complete = '0;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      complete[i] = (wr_cnt_q[i] == need_wr_q[i]) && (seen_mask_q[i] == store_mask_q[i]) &&
                    br_seen_q[i];
    end
  end

  // Valid frames are contiguous from head, so ring distance from head orders them by age.
  always_comb begin
    flush_hit  = flush_valid_i && valid_q[flush_frame_i];
    flush_dist = flush_frame_i - head_q;
    discard    = '0;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      discard[i] = flush_hit && valid_q[i] &&
                   ((FRAME_W'(i) - head_q) >= flush_dist);
    end
  end

  assign alloc_ready_o    = (count_q != CntW'(NUM_FRAMES)) && !flush_valid_i;
  assign alloc_frame_o    = tail_q;
  assign commit_valid_o   = valid_q[head_q] && complete[head_q];
  assign commit_frame_o   = head_q;
  assign commit_exit_id_o = exit_id_q[head_q];
  assign protocol_error_o = error_q;
  assign frames_busy_o    = valid_q;

  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign commit_fire = commit_valid_o && commit_ready_i &&
                       !(flush_hit && (flush_frame_i == head_q));

  always_comb begin
    valid_d      = valid_q;
    br_seen_d    = br_seen_q;
    store_mask_d = store_mask_q;
    seen_mask_d  = seen_mask_q;
    need_wr_d    = need_wr_q;
    wr_cnt_d     = wr_cnt_q;
    exit_id_d    = exit_id_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    error_d      = 1'b0;

    if (flush_valid_i && !flush_hit) error_d = 1'b1;

    if (wr_valid_i) begin
      if (!valid_q[wr_frame_i]) begin
        error_d = 1'b1;
      end else if (!discard[wr_frame_i]) begin
        if (wr_cnt_q[wr_frame_i] == need_wr_q[wr_frame_i]) error_d = 1'b1;
        else wr_cnt_d[wr_frame_i] = wr_cnt_q[wr_frame_i] + 5'd1;
      end
    end

    if (st_valid_i) begin
      if (!valid_q[st_frame_i]) begin
        error_d = 1'b1;
      end else if (!discard[st_frame_i]) begin
        if (seen_mask_q[st_frame_i][st_lsid_i] || !store_mask_q[st_frame_i][st_lsid_i]) begin
          error_d = 1'b1;
        end else begin
          seen_mask_d[st_frame_i][st_lsid_i] = 1'b1;
        end
      end
    end

    if (br_valid_i) begin
      if (!valid_q[br_frame_i]) begin
        error_d = 1'b1;
      end else if (!discard[br_frame_i]) begin
        if (br_seen_q[br_frame_i]) begin
          error_d = 1'b1;
        end else begin
          br_seen_d[br_frame_i] = 1'b1;
          exit_id_d[br_frame_i] = br_exit_id_i;
        end
      end
    end

    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + FRAME_W'(1);
    end

    if (flush_hit) begin
      valid_d = valid_d & ~discard;
      tail_d  = flush_frame_i;
      count_d = {1'b0, flush_dist} - CntW'(commit_fire);
    end else begin
      tail_d  = tail_q + FRAME_W'(alloc_fire);
      count_d = count_q + CntW'(alloc_fire) - CntW'(commit_fire);
    end

    // Allocation is last so it overrides any (erroneous) event to the still-invalid tail frame.
    if (alloc_fire) begin
      valid_d[tail_q]      = 1'b1;
      store_mask_d[tail_q] = alloc_store_mask_i;
      need_wr_d[tail_q]    = alloc_num_reg_writes_i;
      seen_mask_d[tail_q]  = '0;
      wr_cnt_d[tail_q]     = '0;
      br_seen_d[tail_q]    = 1'b0;
      exit_id_d[tail_q]    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      br_seen_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      for (int i = 0; i < NUM_FRAMES; i++) begin
        store_mask_q[i] <= '0;
        seen_mask_q[i]  <= '0;
        need_wr_q[i]    <= '0;
        wr_cnt_q[i]     <= '0;
        exit_id_q[i]    <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      br_seen_q    <= br_seen_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      error_q      <= error_d;
      store_mask_q <= store_mask_d;
      seen_mask_q  <= seen_mask_d;
      need_wr_q    <= need_wr_d;
      wr_cnt_q     <= wr_cnt_d;
      exit_id_q    <= exit_id_d;
    end
  end

endmodule

// File: tb/tb_block_completion_tracker.sv
// Directed bench for block_completion_tracker; commits are checked against a scoreboard queue.
module tb_block_completion_tracker;

  logic        clk;
  logic        rst_n;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [2:0]  alloc_frame;
  logic [31:0] alloc_store_mask;
  logic [4:0]  alloc_num_reg_writes;
  logic        wr_valid;
  logic [2:0]  wr_frame;
  logic        st_valid;
  logic [2:0]  st_frame;
  logic [4:0]  st_lsid;
  logic        br_valid;
  logic [2:0]  br_frame;
  logic [4:0]  br_exit_id;
  logic        flush_valid;
  logic [2:0]  flush_frame;
  logic        commit_valid;
  logic        commit_ready;
  logic [2:0]  commit_frame;
  logic [4:0]  commit_exit_id;
  logic        protocol_error;
  logic [7:0]  frames_busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];  // {frame, exit_id} in expected commit order

  block_completion_tracker dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .alloc_valid_i          (alloc_valid),
    .alloc_ready_o          (alloc_ready),
    .alloc_frame_o          (alloc_frame),
    .alloc_store_mask_i     (alloc_store_mask),
    .alloc_num_reg_writes_i (alloc_num_reg_writes),
    .wr_valid_i             (wr_valid),
    .wr_frame_i             (wr_frame),
    .st_valid_i             (st_valid),
    .st_frame_i             (st_frame),
    .st_lsid_i              (st_lsid),
    .br_valid_i             (br_valid),
    .br_frame_i             (br_frame),
    .br_exit_id_i           (br_exit_id),
    .flush_valid_i          (flush_valid),
    .flush_frame_i          (flush_frame),
    .commit_valid_o         (commit_valid),
    .commit_ready_i         (commit_ready),
    .commit_frame_o         (commit_frame),
    .commit_exit_id_o       (commit_exit_id),
    .protocol_error_o       (protocol_error),
    .frames_busy_o          (frames_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every commit handshake the DUT should honour is compared against the queue.
  always @(negedge clk) begin
    if (rst_n && commit_valid && commit_ready &&
        !(flush_valid && flush_frame == commit_frame)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL commit_unexpected: got frame %0d exit %0d expected none",
                 commit_frame, commit_exit_id);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({commit_frame, commit_exit_id} !== e) begin
          bad++;
          $display("FAIL commit: got frame %0d exit %0d expected frame %0d exit %0d",
                   commit_frame, commit_exit_id, e[7:5], e[4:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    wr_valid    = 1'b0;
    st_valid    = 1'b0;
    br_valid    = 1'b0;
    flush_valid = 1'b0;
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; alloc_store_mask = 0; alloc_num_reg_writes = 0;
    wr_valid = 0; wr_frame = 0; st_valid = 0; st_frame = 0; st_lsid = 0;
    br_valid = 0; br_frame = 0; br_exit_id = 0; flush_valid = 0; flush_frame = 0;
    commit_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [31:0] mask, input logic [4:0] nwr);
    alloc_valid = 1; alloc_store_mask = mask; alloc_num_reg_writes = nwr;
    step();
  endtask

  task automatic wr(input logic [2:0] f);
    wr_valid = 1; wr_frame = f;
    step();
  endtask

  task automatic st(input logic [2:0] f, input logic [4:0] lsid);
    st_valid = 1; st_frame = f; st_lsid = lsid;
    step();
  endtask

  task automatic br(input logic [2:0] f, input logic [4:0] id);
    br_valid = 1; br_frame = f; br_exit_id = id;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alloc_ready"}, alloc_ready, 1);
    chk({tag, "_alloc_frame"}, alloc_frame, 0);
    chk({tag, "_commit_valid"}, commit_valid, 0);
    chk({tag, "_commit_frame"}, commit_frame, 0);
    chk({tag, "_commit_exit_id"}, commit_exit_id, 0);
    chk({tag, "_protocol_error"}, protocol_error, 0);
    chk({tag, "_frames_busy"}, frames_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #3;
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single frame: two writes, two stores, branch, commit.
    alloc(32'h5, 5'd2);
    chk("t1_busy", frames_busy, 8'h01);
    wr(0); wr(0); st(0, 0); st(0, 2);
    chk("t1_not_yet", commit_valid, 0);
    br(0, 5'd3);
    exp_q.push_back({3'd0, 5'd3});
    chk("t1_cvalid", commit_valid, 1);
    chk("t1_cframe", commit_frame, 0);
    chk("t1_cexit", commit_exit_id, 3);
    chk("t1_noerr", protocol_error, 0);
    commit_ready = 1;
    step();
    commit_ready = 0;
    chk("t1_busy_after", frames_busy, 8'h00);
    chk("t1_cvalid_after", commit_valid, 0);

    // Fill all 8 frames, complete out of order, commit in order.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(32'h0, 5'd0);
    chk("t2_full_ready", alloc_ready, 0);
    chk("t2_wrap_frame", alloc_frame, 0);
    chk("t2_busy", frames_busy, 8'hFF);
    br(1, 5'd7);
    chk("t2_young_waits", commit_valid, 0);
    br(0, 5'd9);
    exp_q.push_back({3'd0, 5'd9});
    exp_q.push_back({3'd1, 5'd7});
    chk("t2_head_valid", commit_valid, 1);
    commit_ready = 1;
    step();
    chk("t2_second_valid", commit_valid, 1);
    chk("t2_second_frame", commit_frame, 1);
    step();
    commit_ready = 0;
    chk("t2_busy_after", frames_busy, 8'hFC);
    chk("t2_ready_after", alloc_ready, 1);

    // Flush frame 2 with 4 frames valid; a write to a discarded frame is silently dropped.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h1, 5'd1);
    flush_valid = 1; flush_frame = 2; wr_valid = 1; wr_frame = 3;
    #1;
    chk("t3_ready_in_flush", alloc_ready, 0);
    step();
    chk("t3_busy", frames_busy, 8'h03);
    chk("t3_next_alloc", alloc_frame, 2);
    chk("t3_no_err", protocol_error, 0);

    // Flush of the head blocks a concurrent commit.
    do_reset();
    alloc(32'h0, 5'd0);
    br(0, 5'd5);
    chk("t4_cvalid", commit_valid, 1);
    commit_ready = 1; flush_valid = 1; flush_frame = 0;
    step();
    commit_ready = 0;
    chk("t4_busy", frames_busy, 8'h00);
    chk("t4_cvalid_after", commit_valid, 0);
    chk("t4_tail", alloc_frame, 0);

    // Protocol errors: each pulses for one cycle and leaves state intact.
    do_reset();
    alloc(32'h5, 5'd2);
    st(0, 1);
    chk("t5_err_unmasked", protocol_error, 1);
    st(0, 0);
    chk("t5_ok_st", protocol_error, 0);
    st(0, 0);
    chk("t5_err_dup_st", protocol_error, 1);
    wr(0);
    chk("t5_ok_wr1", protocol_error, 0);
    wr(0);
    chk("t5_ok_wr2", protocol_error, 0);
    wr(0);
    chk("t5_err_wr3", protocol_error, 1);
    br(1, 5'd4);
    chk("t5_err_invalid", protocol_error, 1);
    st(0, 2);
    chk("t5_ok_st2", protocol_error, 0);
    chk("t5_not_yet", commit_valid, 0);
    br(0, 5'd6);
    chk("t5_complete", commit_valid, 1);
    chk("t5_exit", commit_exit_id, 6);
    br(0, 5'd8);
    chk("t5_err_dup_br", protocol_error, 1);
    chk("t5_exit_kept", commit_exit_id, 6);
    exp_q.push_back({3'd0, 5'd6});
    commit_ready = 1;
    step();
    commit_ready = 0;
    chk("t5_busy_after", frames_busy, 8'h00);

    // Asynchronous reset in the middle of activity.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h0, 5'd0);
    br(0, 5'd2);
    chk("t6_cvalid", commit_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t6_alloc_frame", alloc_frame, 0);
    chk("t6_busy", frames_busy, 0);

    step();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
